// File: rtl/pong_pkg.sv
// Shared pong geometry, FSM state and direction encodings, plus the
// span-overlap helper used by the ball/paddle collision checks.
package pong_pkg;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned BALL_SIZE   = 8;
  localparam int unsigned PADDLE_H    = 64;
  localparam int unsigned PADDLE_W    = 8;
  localparam int unsigned PADDLE_X_L  = 16;
  localparam int unsigned PADDLE_X_R  = 616;
  localparam int unsigned SPEED       = 2;
  localparam int unsigned SERVE_DELAY = 60;
  localparam int unsigned COORD_W     = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    HALT  = 2'd2
  } state_e;

  typedef enum logic {
    DIR_NEG = 1'b0,
    DIR_POS = 1'b1
  } dir_e;

  // Half-open spans [a_lo, a_hi) and [b_lo, b_hi) intersect.
  function automatic logic span_overlap(input logic [COORD_W:0] a_lo,
                                        input logic [COORD_W:0] a_hi,
                                        input logic [COORD_W:0] b_lo,
                                        input logic [COORD_W:0] b_hi);
    return (a_hi > b_lo) && (a_lo < b_hi);
  endfunction

endpackage

// File: rtl/ball_engine_if.sv
// Frame/paddle inputs and ball position/event outputs of ball_engine.
interface ball_engine_if;
  import pong_pkg::*;

  logic   tick;
  logic   game_over;
  coord_t paddle_left_y;
  coord_t paddle_right_y;
  coord_t ball_x;
  coord_t ball_y;
  logic   hit_left;
  logic   hit_right;
  logic   miss_left;
  logic   miss_right;
  logic   serving;

  modport master (
    output tick, game_over, paddle_left_y, paddle_right_y,
    input  ball_x, ball_y, hit_left, hit_right, miss_left, miss_right, serving
  );

  modport slave (
    input  tick, game_over, paddle_left_y, paddle_right_y,
    output ball_x, ball_y, hit_left, hit_right, miss_left, miss_right, serving
  );
endinterface

// File: rtl/ball_engine_serve_timer.sv
// Tick-enabled serve counter; done fires on the enable that finds it at
// DELAY-1, and the counter wraps to zero on that same enable.
module serve_timer #(
  parameter int unsigned DELAY = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic done
);
  localparam int unsigned W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [W-1:0] LAST = W'(DELAY - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    done  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr || done) cnt_d = '0;
    else if (en)     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/ball_engine.sv
// Ball motion, wall bounces and paddle hit/miss detection for pong; all
// outputs registered, events are one-cycle pulses after the causing tick.
module ball_engine #(
  parameter int unsigned SCREEN_W    = pong_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H    = pong_pkg::SCREEN_H,
  parameter int unsigned BALL_SIZE   = pong_pkg::BALL_SIZE,
  parameter int unsigned PADDLE_H    = pong_pkg::PADDLE_H,
  parameter int unsigned PADDLE_W    = pong_pkg::PADDLE_W,
  parameter int unsigned PADDLE_X_L  = pong_pkg::PADDLE_X_L,
  parameter int unsigned PADDLE_X_R  = pong_pkg::PADDLE_X_R,
  parameter int unsigned SPEED       = pong_pkg::SPEED,
  parameter int unsigned SERVE_DELAY = pong_pkg::SERVE_DELAY
) (
  input logic          clk,
  input logic          reset,
  ball_engine_if.slave bus
);
  import pong_pkg::*;

  localparam logic [9:0]  CENTER_X = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  CENTER_Y = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [10:0] FACE_L   = 11'(PADDLE_X_L + PADDLE_W);
  localparam logic [10:0] FACE_R   = 11'(PADDLE_X_R - BALL_SIZE);
  localparam logic [10:0] SPD      = 11'(SPEED);
  localparam logic [10:0] BS       = 11'(BALL_SIZE);
  localparam logic [10:0] PH       = 11'(PADDLE_H);
  localparam logic [10:0] SW       = 11'(SCREEN_W);
  localparam logic [10:0] SH       = 11'(SCREEN_H);

  state_e     state_q, state_d;
  dir_e       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [9:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic       hit_left_q, hit_left_d, hit_right_q, hit_right_d;
  logic       miss_left_q, miss_left_d, miss_right_q, miss_right_d;
  logic       serving_q, serving_d;
  logic       timer_en, timer_clr, timer_done;

  // One spare bit so every compare/add below is free of wrap-around.
  logic [10:0] bx, by, pl, pr;
  logic        overlap_l, overlap_r;

  assign bx        = {1'b0, ball_x_q};
  assign by        = {1'b0, ball_y_q};
  assign pl        = {1'b0, bus.paddle_left_y};
  assign pr        = {1'b0, bus.paddle_right_y};
  assign overlap_l = span_overlap(by, by + BS, pl, pl + PH);
  assign overlap_r = span_overlap(by, by + BS, pr, pr + PH);

  serve_timer #(.DELAY(SERVE_DELAY)) u_serve_timer (
    .clk  (clk),
    .rst  (reset),
    .en   (timer_en),
    .clr  (timer_clr),
    .done (timer_done)
  );

  always_comb begin
    state_d      = state_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    ball_x_d     = ball_x_q;
    ball_y_d     = ball_y_q;
    hit_left_d   = 1'b0;
    hit_right_d  = 1'b0;
    miss_left_d  = 1'b0;
    miss_right_d = 1'b0;
    timer_en     = 1'b0;
    timer_clr    = (state_q != SERVE);

    case (state_q)
      SERVE: begin
        if (bus.game_over) begin
          state_d = HALT;
        end else if (bus.tick) begin
          timer_en = 1'b1;
          if (timer_done) state_d = PLAY;
        end
      end
      PLAY: begin
        if (bus.game_over) begin
          state_d = HALT;
        end else if (bus.tick) begin
          if (dir_y_q == DIR_POS) begin
            if (by + BS + SPD >= SH) begin
              ball_y_d = 10'(SH - BS);
              dir_y_d  = DIR_NEG;
            end else begin
              ball_y_d = 10'(by + SPD);
            end
          end else begin
            if (by < SPD) begin
              ball_y_d = '0;
              dir_y_d  = DIR_POS;
            end else begin
              ball_y_d = 10'(by - SPD);
            end
          end
          // Overlap uses the pre-move ball_y; a miss overrides the Y result.
          if (dir_x_q == DIR_NEG) begin
            if (bx >= FACE_L && bx < FACE_L + SPD && overlap_l) begin
              ball_x_d   = 10'(FACE_L);
              dir_x_d    = DIR_POS;
              hit_left_d = 1'b1;
            end else if (bx < SPD) begin
              miss_left_d = 1'b1;
              ball_x_d    = CENTER_X;
              ball_y_d    = CENTER_Y;
              dir_x_d     = DIR_NEG;
              state_d     = SERVE;
            end else begin
              ball_x_d = 10'(bx - SPD);
            end
          end else begin
            if (bx <= FACE_R && bx + SPD > FACE_R && overlap_r) begin
              ball_x_d    = 10'(FACE_R);
              dir_x_d     = DIR_NEG;
              hit_right_d = 1'b1;
            end else if (bx + BS + SPD > SW) begin
              miss_right_d = 1'b1;
              ball_x_d     = CENTER_X;
              ball_y_d     = CENTER_Y;
              dir_x_d      = DIR_POS;
              state_d      = SERVE;
            end else begin
              ball_x_d = 10'(bx + SPD);
            end
          end
        end
      end
      HALT: begin
        if (!bus.game_over) begin
          state_d  = SERVE;
          ball_x_d = CENTER_X;
          ball_y_d = CENTER_Y;
        end
      end
      default: state_d = SERVE;
    endcase

    serving_d = (state_d == SERVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SERVE;
      dir_x_q      <= DIR_POS;
      dir_y_q      <= DIR_POS;
      ball_x_q     <= CENTER_X;
      ball_y_q     <= CENTER_Y;
      hit_left_q   <= 1'b0;
      hit_right_q  <= 1'b0;
      miss_left_q  <= 1'b0;
      miss_right_q <= 1'b0;
      serving_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      hit_left_q   <= hit_left_d;
      hit_right_q  <= hit_right_d;
      miss_left_q  <= miss_left_d;
      miss_right_q <= miss_right_d;
      serving_q    <= serving_d;
    end
  end

  assign bus.ball_x     = ball_x_q;
  assign bus.ball_y     = ball_y_q;
  assign bus.hit_left   = hit_left_q;
  assign bus.hit_right  = hit_right_q;
  assign bus.miss_left  = miss_left_q;
  assign bus.miss_right = miss_right_q;
  assign bus.serving    = serving_q;
endmodule
